prv_trap_sequencer: RTL
=======================

// Module: prv_trap_sequencer
// PURPOSE
//  Sequences machine-mode trap entry and MRET for the privilege block. Prioritises exception
//  and interrupt sources, drains the pipeline, commits mcause/mepc/mbadaddr/mstatus in one
//  atomic cycle, then redirects fetch. Sits between the pipeline hazard unit and the CSR file.
// PARAMETERS
//  (none) -- XLEN fixed at 32 via rv32i_types_pkg::word_t
// PORTS
//  CLK            in   1   system clock
//  RST            in   1   asynchronous reset, active-high
//  exc_src        in   9   {fault_l,fault_s,mal_l,mal_s,env_m,illegal_insn,mal_insn,fault_insn,breakpoint}
//  irq_pend       in   3   {ext,timer,soft} pending (mip)
//  irq_en         in   3   {ext,timer,soft} enables (mie)
//  mstatus_mie    in   1   current global interrupt enable
//  mstatus_mpie   in   1   current previous-enable
//  ret            in   1   MRET retiring
//  epc            in   32  PC of faulting/interrupted instruction
//  badaddr        in   32  faulting address
//  pipe_clear     in   1   pipeline drained
//  mtvec          in   32  trap vector CSR
//  mepc           in   32  current mepc (MRET target)
//  intr           out  1   flush request to pipeline
//  busy           out  1   state != IDLE
//  mcause_rup / mepc_rup / mbadaddr_rup / mstatus_rup  out 1 each  CSR write strobes
//  mcause_next    out  32  {interrupt, 27'b0, code[3:0]}
//  mepc_next      out  32  latched epc
//  mbadaddr_next  out  32  latched badaddr
//  mie_next       out  1   new mstatus.MIE
//  mpie_next      out  1   new mstatus.MPIE
//  insert_pc      out  1   fetch redirect strobe
//  priv_pc        out  32  redirect target
// BEHAVIOUR
//  States: IDLE, DRAIN, COMMIT, RET_DRAIN, RET_COMMIT, REDIRECT. Reset: IDLE, all outputs 0.
//  IDLE: any exc_src -> latch cause/epc/badaddr, go DRAIN. Else (irq_pend&irq_en)!=0 && mstatus_mie
//   -> latch interrupt cause, epc, go DRAIN. Else ret -> RET_DRAIN. Exception beats interrupt beats ret.
//  Exception priority/code: breakpoint 3 > fault_insn 1 > mal_insn 0 > illegal 2 > env_m 11 >
//   mal_s 6 > mal_l 4 > fault_s 7 > fault_l 5. Interrupt: ext 11 > soft 3 > timer 7, mcause[31]=1.
//  DRAIN/RET_DRAIN: intr=1 until pipe_clear sampled high; then COMMIT/RET_COMMIT. pipe_clear
//   already high costs one DRAIN cycle.
//  COMMIT (1 cycle): mcause_rup=mepc_rup=mstatus_rup=1; mbadaddr_rup=1 only for codes 0,1,4,5,6,7;
//   mie_next=0, mpie_next=mstatus_mie; target={mtvec[31:2],2'b00}.
//  RET_COMMIT (1 cycle): mstatus_rup=1, mie_next=mstatus_mpie, mpie_next=1; target=mepc.
//  REDIRECT (1 cycle): insert_pc=1, priv_pc=target; -> IDLE.
//  Latency: source at IDLE cycle 0, pipe_clear high -> COMMIT cycle 2, insert_pc cycle 3.
//  Sources arriving while busy are not latched; pipeline holds exceptions, interrupts are level.
//  Strobes fire only in COMMIT states; reset mid-sequence leaves CSRs untouched, returns to IDLE.
//  *_next outputs are 0 outside COMMIT/RET_COMMIT.
// CONFIGURATION
//  PRV_VECTORED_EN defined: interrupt trap with mtvec[1:0]==2'b01 ->
//   target={mtvec[31:2],2'b00}+(code<<2); exceptions still use base.
//  Undefined: mtvec[1:0] ignored, always base.
// STRUCTURE
//  machine_mode_types_pkg gains: trap_state_t enum, exception/interrupt cause code constants, exc_src bit indices.
//  Sub-module prv_trap_prio: combinational priority encoder (exc_src, irq_pend&irq_en,
//   mstatus_mie) -> {valid, is_intr, code[3:0]}.
// TESTING
//  exc_src=illegal|mal_l, epc=0x100, mtvec=0x8000_0000, pipe_clear=1
//   -> cycle 2: mcause_next=2, mepc_next=0x100, mbadaddr_rup=0; cycle 3: insert_pc, priv_pc=0x8000_0000.
//  irq_pend=3'b110, irq_en=3'b111, mstatus_mie=1 -> mcause_next=0x8000_000B; mie_next=0, mpie_next=1.
//  Timer pending+enabled, mstatus_mie=0 -> stays IDLE, no strobes.
//  ret=1, mstatus_mpie=1, mepc=0x2040 -> RET_COMMIT mie_next=1, mpie_next=1; priv_pc=0x2040.
//  Exception with pipe_clear low 5 cycles -> intr high 5 cycles, no strobes until clear; RST in DRAIN -> IDLE, no strobes.
//  PRV_VECTORED_EN, mtvec=0x8000_0001, timer irq -> priv_pc=0x8000_001C; same with ecall -> 0x8000_0000.

Source files
------------

// File: rtl/prv_trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Holds the sequencer state encoding, the exc_src bit positions and the
// mcause exception/interrupt codes.
package prv_trap_sequencer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_COMMIT     = 3'd2,
    ST_RET_DRAIN  = 3'd3,
    ST_RET_COMMIT = 3'd4,
    ST_REDIRECT   = 3'd5
  } trap_state_t;

  // exc_src bit positions: {fault_l,fault_s,mal_l,mal_s,env_m,illegal,mal_insn,fault_insn,breakpoint}
  localparam int unsigned EXC_BREAKPOINT = 0;
  localparam int unsigned EXC_FAULT_INSN = 1;
  localparam int unsigned EXC_MAL_INSN   = 2;
  localparam int unsigned EXC_ILLEGAL    = 3;
  localparam int unsigned EXC_ENV_M      = 4;
  localparam int unsigned EXC_MAL_S      = 5;
  localparam int unsigned EXC_MAL_L      = 6;
  localparam int unsigned EXC_FAULT_S    = 7;
  localparam int unsigned EXC_FAULT_L    = 8;

  // irq bit positions: {ext,timer,soft}
  localparam int unsigned IRQ_SOFT  = 0;
  localparam int unsigned IRQ_TIMER = 1;
  localparam int unsigned IRQ_EXT   = 2;

  // Exception cause codes
  localparam logic [3:0] CAUSE_MAL_INSN   = 4'd0;
  localparam logic [3:0] CAUSE_FAULT_INSN = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_MAL_L      = 4'd4;
  localparam logic [3:0] CAUSE_FAULT_L    = 4'd5;
  localparam logic [3:0] CAUSE_MAL_S      = 4'd6;
  localparam logic [3:0] CAUSE_FAULT_S    = 4'd7;
  localparam logic [3:0] CAUSE_ENV_M      = 4'd11;

  // Interrupt cause codes (mcause[31] set)
  localparam logic [3:0] IRQ_CODE_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

  // Address-related exceptions carry a meaningful badaddr
  function automatic logic needs_badaddr(input logic [3:0] code);
    return (code == CAUSE_MAL_INSN) || (code == CAUSE_FAULT_INSN) ||
           (code == CAUSE_MAL_L)    || (code == CAUSE_FAULT_L)    ||
           (code == CAUSE_MAL_S)    || (code == CAUSE_FAULT_S);
  endfunction

endpackage

// File: rtl/prv_trap_sequencer_prio.sv
// Combinational trap source priority encoder.
// Exceptions always win over interrupts; interrupts only count when the
// global enable is set. Produces {valid, is_intr, code}.
module prv_trap_sequencer_prio
  import prv_trap_sequencer_pkg::*;
(
  input  logic [8:0] exc_src_i,
  input  logic [2:0] irq_act_i,
  input  logic       mstatus_mie_i,
  output logic       valid_o,
  output logic       is_intr_o,
  output logic [3:0] code_o
);

  // Fixed-priority selection of the winning cause
  always_comb begin
    valid_o   = 1'b1;
    is_intr_o = 1'b0;
    code_o    = 4'd0;
    if      (exc_src_i[EXC_BREAKPOINT]) code_o = CAUSE_BREAKPOINT;
    else if (exc_src_i[EXC_FAULT_INSN]) code_o = CAUSE_FAULT_INSN;
    else if (exc_src_i[EXC_MAL_INSN])   code_o = CAUSE_MAL_INSN;
    else if (exc_src_i[EXC_ILLEGAL])    code_o = CAUSE_ILLEGAL;
    else if (exc_src_i[EXC_ENV_M])      code_o = CAUSE_ENV_M;
    else if (exc_src_i[EXC_MAL_S])      code_o = CAUSE_MAL_S;
    else if (exc_src_i[EXC_MAL_L])      code_o = CAUSE_MAL_L;
    else if (exc_src_i[EXC_FAULT_S])    code_o = CAUSE_FAULT_S;
    else if (exc_src_i[EXC_FAULT_L])    code_o = CAUSE_FAULT_L;
    else if (mstatus_mie_i && (irq_act_i != 3'b000)) begin
      is_intr_o = 1'b1;
      if      (irq_act_i[IRQ_EXT])  code_o = IRQ_CODE_EXT;
      else if (irq_act_i[IRQ_SOFT]) code_o = IRQ_CODE_SOFT;
      else                          code_o = IRQ_CODE_TIMER;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer.
// IDLE -> DRAIN -> COMMIT -> REDIRECT for traps, IDLE -> RET_DRAIN ->
// RET_COMMIT -> REDIRECT for MRET. All outputs are registered.
// Optional feature: define PRV_VECTORED_EN to enable vectored interrupt
// dispatch when mtvec[1:0] == 2'b01.
module prv_trap_sequencer
  import prv_trap_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [8:0]  exc_src_i,
  input  logic [2:0]  irq_pend_i,
  input  logic [2:0]  irq_en_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_mpie_i,
  input  logic        ret_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] badaddr_i,
  input  logic        pipe_clear_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        intr_o,
  output logic        busy_o,
  output logic        mcause_rup_o,
  output logic        mepc_rup_o,
  output logic        mbadaddr_rup_o,
  output logic        mstatus_rup_o,
  output logic [31:0] mcause_next_o,
  output logic [31:0] mepc_next_o,
  output logic [31:0] mbadaddr_next_o,
  output logic        mie_next_o,
  output logic        mpie_next_o,
  output logic        insert_pc_o,
  output logic [31:0] priv_pc_o
);

  trap_state_t state_q;
  logic        is_intr_q;
  logic [3:0]  code_q;
  word_t       epc_q, badaddr_q, target_q;
  logic        intr_q, mcause_rup_q, mepc_rup_q, mbadaddr_rup_q, mstatus_rup_q;
  word_t       mcause_next_q, mepc_next_q, mbadaddr_next_q, priv_pc_q;
  logic        mie_next_q, mpie_next_q, insert_pc_q;

  logic        prio_valid, prio_is_intr;
  logic [3:0]  prio_code;
  word_t       trap_target_d;

  prv_trap_sequencer_prio u_prio (
    .exc_src_i     (exc_src_i),
    .irq_act_i     (irq_pend_i & irq_en_i),
    .mstatus_mie_i (mstatus_mie_i),
    .valid_o       (prio_valid),
    .is_intr_o     (prio_is_intr),
    .code_o        (prio_code)
  );

  // Trap vector target: base, or base + 4*code for vectored interrupts
`ifdef PRV_VECTORED_EN
  always_comb begin
    trap_target_d = {mtvec_i[31:2], 2'b00};
    if (is_intr_q && (mtvec_i[1:0] == 2'b01))
      trap_target_d = {mtvec_i[31:2], 2'b00} + {26'd0, code_q, 2'b00};
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign trap_target_d     = {mtvec_i[31:2], 2'b00};
`endif

  // Sequencer FSM; strobes and *_next default to zero every cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      is_intr_q       <= 1'b0;
      code_q          <= 4'd0;
      epc_q           <= '0;
      badaddr_q       <= '0;
      target_q        <= '0;
      intr_q          <= 1'b0;
      mcause_rup_q    <= 1'b0;
      mepc_rup_q      <= 1'b0;
      mbadaddr_rup_q  <= 1'b0;
      mstatus_rup_q   <= 1'b0;
      mcause_next_q   <= '0;
      mepc_next_q     <= '0;
      mbadaddr_next_q <= '0;
      mie_next_q      <= 1'b0;
      mpie_next_q     <= 1'b0;
      insert_pc_q     <= 1'b0;
      priv_pc_q       <= '0;
    end else begin
      intr_q          <= 1'b0;
      mcause_rup_q    <= 1'b0;
      mepc_rup_q      <= 1'b0;
      mbadaddr_rup_q  <= 1'b0;
      mstatus_rup_q   <= 1'b0;
      mcause_next_q   <= '0;
      mepc_next_q     <= '0;
      mbadaddr_next_q <= '0;
      mie_next_q      <= 1'b0;
      mpie_next_q     <= 1'b0;
      insert_pc_q     <= 1'b0;
      priv_pc_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (prio_valid) begin
            is_intr_q <= prio_is_intr;
            code_q    <= prio_code;
            epc_q     <= epc_i;
            badaddr_q <= prio_is_intr ? '0 : badaddr_i;
            intr_q    <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (ret_i) begin
            intr_q  <= 1'b1;
            state_q <= ST_RET_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_clear_i) begin
            mcause_rup_q    <= 1'b1;
            mepc_rup_q      <= 1'b1;
            mstatus_rup_q   <= 1'b1;
            mbadaddr_rup_q  <= !is_intr_q && needs_badaddr(code_q);
            mcause_next_q   <= {is_intr_q, 27'd0, code_q};
            mepc_next_q     <= epc_q;
            mbadaddr_next_q <= badaddr_q;
            mie_next_q      <= 1'b0;
            mpie_next_q     <= mstatus_mie_i;
            target_q        <= trap_target_d;
            state_q         <= ST_COMMIT;
          end else begin
            intr_q <= 1'b1;
          end
        end
        ST_RET_DRAIN: begin
          if (pipe_clear_i) begin
            mstatus_rup_q <= 1'b1;
            mie_next_q    <= mstatus_mpie_i;
            mpie_next_q   <= 1'b1;
            target_q      <= mepc_i;
            state_q       <= ST_RET_COMMIT;
          end else begin
            intr_q <= 1'b1;
          end
        end
        ST_COMMIT, ST_RET_COMMIT: begin
          insert_pc_q <= 1'b1;
          priv_pc_q   <= target_q;
          state_q     <= ST_REDIRECT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign intr_o          = intr_q;
  assign mcause_rup_o    = mcause_rup_q;
  assign mepc_rup_o      = mepc_rup_q;
  assign mbadaddr_rup_o  = mbadaddr_rup_q;
  assign mstatus_rup_o   = mstatus_rup_q;
  assign mcause_next_o   = mcause_next_q;
  assign mepc_next_o     = mepc_next_q;
  assign mbadaddr_next_o = mbadaddr_next_q;
  assign mie_next_o      = mie_next_q;
  assign mpie_next_o     = mpie_next_q;
  assign insert_pc_o     = insert_pc_q;
  assign priv_pc_o       = priv_pc_q;

endmodule
